// File: rtl/fir_tap_buffer_ctrl.sv
// Circular sample-history controller for the FIR datapath: writes each accepted sample
// into a TAPS-entry block RAM, then streams the last TAPS samples newest-to-oldest.
module fir_tap_buffer_ctrl #(
   parameter int ADDR_WIDTH = 12,
   parameter int BIT_WIDTH  = 32,
   parameter int TAPS       = 11
) (
   input  logic                  axis_clk,
   input  logic                  axis_rst_n,
   input  logic                  clear,
   input  logic                  ss_tvalid,
   output logic                  ss_tready,
   input  logic [BIT_WIDTH-1:0]  ss_tdata,
   input  logic                  ss_tlast,
   output logic                  sm_tvalid,
   input  logic                  sm_tready,
   output logic [BIT_WIDTH-1:0]  sm_tdata,
   output logic                  sm_tlast,
   output logic                  sm_teos,
   output logic                  busy,
   output logic                  bram_we,
   output logic                  bram_re,
   output logic [ADDR_WIDTH-1:0] bram_waddr,
   output logic [ADDR_WIDTH-1:0] bram_raddr,
   output logic [BIT_WIDTH-1:0]  bram_wdi,
   input  logic [BIT_WIDTH-1:0]  bram_rdo
);

   typedef enum logic [1:0] {INIT, IDLE, BURST} state_e;

   localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(TAPS - 1);
   localparam logic [ADDR_WIDTH-1:0] TAPS_A = ADDR_WIDTH'(TAPS);
   localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] head_q, head_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0] k_q, k_d;      // init write address in INIT, beat index in BURST
   logic                  sm_tvalid_q, sm_tvalid_d;
   logic                  sm_tlast_q, sm_tlast_d;
   logic                  sm_teos_q, sm_teos_d;
   logic                  issue;
   logic                  handshake;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values computed by the combinational block.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q     <= INIT;
         head_q      <= '0;
         rd_ptr_q    <= '0;
         k_q         <= '0;
         sm_tvalid_q <= 1'b0;
         sm_tlast_q  <= 1'b0;
         sm_teos_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         rd_ptr_q    <= rd_ptr_d;
         k_q         <= k_d;
         sm_tvalid_q <= sm_tvalid_d;
         sm_tlast_q  <= sm_tlast_d;
         sm_teos_q   <= sm_teos_d;
      end
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned,
      // which would otherwise infer a latch.
      state_d     = state_q;
      head_d      = head_q;
      rd_ptr_d    = rd_ptr_q;
      k_d         = k_q;
      sm_tvalid_d = sm_tvalid_q;
      sm_tlast_d  = sm_tlast_q;
      sm_teos_d   = sm_teos_q;
      ss_tready   = 1'b0;
      bram_we     = 1'b0;
      bram_waddr  = '0;
      bram_wdi    = '0;
      bram_re     = 1'b0;
      bram_raddr  = '0;
      issue       = 1'b0;
      handshake   = 1'b0;

      unique case (state_q)
         INIT: begin
            // NOTE: the zero-fill write is qualified by reset so the RAM sees no
            // write strobe while reset is held; reset itself never clears the RAM.
            bram_we    = axis_rst_n;
            bram_waddr = k_q;
            if (k_q == LAST_A) begin
               state_d = IDLE;
               k_d     = '0;
            end else begin
               k_d = k_q + ONE_A;
            end
         end

         IDLE: begin
            ss_tready = !clear;
            if (clear) begin
               state_d = INIT;
               head_d  = '0;
               k_d     = '0;
            end else if (ss_tvalid) begin
               bram_we    = 1'b1;
               bram_waddr = head_q;
               bram_wdi   = ss_tdata;
               sm_teos_d  = ss_tlast;
               rd_ptr_d   = head_q;
               k_d        = '0;
               head_d     = (head_q == LAST_A) ? '0 : head_q + ONE_A;
               state_d    = BURST;
            end
         end

         BURST: begin
            // Only read when the output slot frees up, so bram_rdo holds a stalled beat.
            issue     = (k_q < TAPS_A) && (!sm_tvalid_q || sm_tready);
            handshake = sm_tvalid_q && sm_tready;
            if (issue) begin
               bram_re     = 1'b1;
               bram_raddr  = rd_ptr_q;
               rd_ptr_d    = (rd_ptr_q == '0) ? LAST_A : rd_ptr_q - ONE_A;
               k_d         = k_q + ONE_A;
               sm_tvalid_d = 1'b1;
               sm_tlast_d  = (k_q == LAST_A);
            end else if (handshake) begin
               sm_tvalid_d = 1'b0;
               sm_tlast_d  = 1'b0;
            end
            if (handshake && sm_tlast_q) begin
               state_d = IDLE;
            end
         end

         default: state_d = INIT;
      endcase
   end

   assign sm_tvalid = sm_tvalid_q;
   assign sm_tlast  = sm_tlast_q;
   assign sm_teos   = sm_teos_q;
   assign sm_tdata  = bram_rdo;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fir_tap_buffer_ctrl.sv
// Directed bench for fir_tap_buffer_ctrl with a behavioural registered-read RAM and
// a scoreboard of expected output beats built from an independent history model.
module tb_fir_tap_buffer_ctrl;
   localparam int AW = 12;
   localparam int BW = 32;
   localparam int TAPS = 11;

   logic          axis_clk = 1'b0;
   logic          axis_rst_n;
   logic          clear;
   logic          ss_tvalid;
   logic          ss_tready;
   logic [BW-1:0] ss_tdata;
   logic          ss_tlast;
   logic          sm_tvalid;
   logic          sm_tready;
   logic [BW-1:0] sm_tdata;
   logic          sm_tlast;
   logic          sm_teos;
   logic          busy;
   logic          bram_we;
   logic          bram_re;
   logic [AW-1:0] bram_waddr;
   logic [AW-1:0] bram_raddr;
   logic [BW-1:0] bram_wdi;
   logic [BW-1:0] bram_rdo;

   fir_tap_buffer_ctrl #(.ADDR_WIDTH(AW), .BIT_WIDTH(BW), .TAPS(TAPS)) dut (
      .axis_clk   (axis_clk),
      .axis_rst_n (axis_rst_n),
      .clear      (clear),
      .ss_tvalid  (ss_tvalid),
      .ss_tready  (ss_tready),
      .ss_tdata   (ss_tdata),
      .ss_tlast   (ss_tlast),
      .sm_tvalid  (sm_tvalid),
      .sm_tready  (sm_tready),
      .sm_tdata   (sm_tdata),
      .sm_tlast   (sm_tlast),
      .sm_teos    (sm_teos),
      .busy       (busy),
      .bram_we    (bram_we),
      .bram_re    (bram_re),
      .bram_waddr (bram_waddr),
      .bram_raddr (bram_raddr),
      .bram_wdi   (bram_wdi),
      .bram_rdo   (bram_rdo)
   );

   always #5 axis_clk = ~axis_clk;

   // Behavioural simple dual-port RAM, preloaded with junk so the zero-fill is visible.
   logic [BW-1:0] mem [TAPS];
   initial for (int i = 0; i < TAPS; i++) mem[i] = 32'hDEAD_0000 + i;
   always @(posedge axis_clk) begin
      if (bram_we) begin
         if (int'(bram_waddr) < TAPS) mem[bram_waddr] <= bram_wdi;
      end
      if (bram_re) bram_rdo <= (int'(bram_raddr) < TAPS) ? mem[bram_raddr] : 'x;
   end

   typedef struct {
      logic [BW-1:0] data;
      logic          last;
      logic          eos;
   } beat_t;

   beat_t         exp_q[$];
   logic [BW-1:0] model_mem [TAPS];
   int            model_head;
   int            vectors = 0;
   int            miscompares = 0;
   int            cyc = 0;
   int            beats_seen = 0;
   int            hs_total = 0;
   int            first_beat_cyc = -1;
   int            last_beat_cyc = -1;
   int            acc_cyc = -1;
   int            idle_cyc = -1;

   always @(posedge axis_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_zero();
      for (int i = 0; i < TAPS; i++) model_mem[i] = '0;
      model_head = 0;
   endtask

   // Output monitor: pops the scoreboard on each handshake and polices stalls.
   initial forever begin
      @(negedge axis_clk);
      if (!axis_rst_n) begin
         beats_seen = 0;
      end else begin
         check("we_re_exclusive", {31'b0, bram_we && bram_re}, 0);
         if (sm_tvalid && !sm_tready) begin
            check("stall_no_read", {31'b0, bram_re}, 0);
            if (exp_q.size() > 0) check("stall_data_stable", sm_tdata, exp_q[0].data);
         end
         if (sm_tvalid && sm_tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", {31'b0, sm_tvalid}, 0);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("beat_data", sm_tdata, e.data);
               check("beat_last", {31'b0, sm_tlast}, {31'b0, e.last});
               check("beat_eos", {31'b0, sm_teos}, {31'b0, e.eos});
               if (beats_seen == 0) first_beat_cyc = cyc;
               if (sm_tlast) last_beat_cyc = cyc;
               hs_total++;
               beats_seen = sm_tlast ? 0 : beats_seen + 1;
            end
         end
      end
   end

   // Called at posedge+1 of the first INIT cycle.
   task automatic check_init();
      for (int i = 0; i < TAPS; i++) begin
         @(negedge axis_clk);
         check("init_we", {31'b0, bram_we}, 1);
         check("init_waddr", {20'b0, bram_waddr}, i);
         check("init_wdi", bram_wdi, 0);
         check("init_ready", {31'b0, ss_tready}, 0);
         check("init_busy", {31'b0, busy}, 1);
         @(posedge axis_clk);
         #1;
      end
      @(negedge axis_clk);
      check("init_done_ready", {31'b0, ss_tready}, 1);
      check("init_done_busy", {31'b0, busy}, 0);
      @(posedge axis_clk);
      #1;
   endtask

   // Presents one sample, records the expected burst at acceptance; returns at posedge+1.
   task automatic send(input logic [BW-1:0] v, input logic last);
      int n = 0;
      ss_tvalid = 1'b1;
      ss_tdata  = v;
      ss_tlast  = last;
      @(negedge axis_clk);
      while (!ss_tready && n < 100) begin
         @(negedge axis_clk);
         n++;
      end
      check("accept_wait", {31'b0, ss_tready}, 1);
      if (ss_tready) begin
         acc_cyc = cyc;
         model_mem[model_head] = v;
         for (int k = 0; k < TAPS; k++) begin
            beat_t b;
            b.data = model_mem[(model_head - k + TAPS) % TAPS];
            b.last = (k == TAPS - 1);
            b.eos  = last;
            exp_q.push_back(b);
         end
         model_head = (model_head + 1) % TAPS;
      end
      @(posedge axis_clk);
      #1;
      ss_tvalid = 1'b0;
      ss_tlast  = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge axis_clk);
      while (busy && n < 200) begin
         @(negedge axis_clk);
         n++;
      end
      check("idle_wait", {31'b0, busy}, 0);
      idle_cyc = cyc;
      check("burst_drained", exp_q.size(), 0);
      @(posedge axis_clk);
      #1;
   endtask

   initial begin
      int hs0;
      int n;
      axis_rst_n = 1'b0;
      clear      = 1'b0;
      ss_tvalid  = 1'b0;
      ss_tdata   = '0;
      ss_tlast   = 1'b0;
      sm_tready  = 1'b1;
      model_zero();
      #12;
      // Reset values
      check("rst_ss_tready", {31'b0, ss_tready}, 0);
      check("rst_sm_tvalid", {31'b0, sm_tvalid}, 0);
      check("rst_sm_tlast", {31'b0, sm_tlast}, 0);
      check("rst_sm_teos", {31'b0, sm_teos}, 0);
      check("rst_bram_we", {31'b0, bram_we}, 0);
      check("rst_bram_re", {31'b0, bram_re}, 0);
      check("rst_waddr", {20'b0, bram_waddr}, 0);
      check("rst_raddr", {20'b0, bram_raddr}, 0);
      check("rst_wdi", bram_wdi, 0);
      check("rst_busy", {31'b0, busy}, 1);
      @(posedge axis_clk);
      #1;
      axis_rst_n = 1'b1;
      check_init();

      // Single sample and burst timing
      send(32'd5, 1'b0);
      wait_idle();
      check("first_beat_cycle", first_beat_cyc, acc_cyc + 2);
      check("last_beat_cycle", last_beat_cyc, acc_cyc + TAPS + 1);
      check("idle_cycle", idle_cyc, acc_cyc + TAPS + 2);

      // Sequence 1..12 wraps the head past the last entry
      for (int v = 1; v <= 12; v++) begin
         send(v, 1'b0);
         wait_idle();
      end

      // Backpressure 1,0,0,1 on the burst for 7
      hs0 = hs_total;
      send(32'd7, 1'b0);
      n = 0;
      while ((busy || exp_q.size() > 0) && n < 200) begin
         sm_tready = (n % 4 == 0) || (n % 4 == 3);
         @(posedge axis_clk);
         #1;
         n++;
      end
      sm_tready = 1'b1;
      check("stall_burst_done", {31'b0, busy}, 0);
      check("stall_handshakes", hs_total - hs0, TAPS);

      // Clear beats a simultaneous sample
      for (int v = 1; v <= 3; v++) begin
         send(v, 1'b0);
         wait_idle();
      end
      clear     = 1'b1;
      ss_tvalid = 1'b1;
      ss_tdata  = 32'hBAD;
      @(negedge axis_clk);
      check("clear_ready", {31'b0, ss_tready}, 0);
      check("clear_no_write", {31'b0, bram_we}, 0);
      @(posedge axis_clk);
      #1;
      clear     = 1'b0;
      ss_tvalid = 1'b0;
      model_zero();
      check_init();
      send(32'd9, 1'b0);
      wait_idle();

      // Reset in the middle of a burst
      send(32'h44, 1'b0);
      n = 0;
      while (!(sm_tvalid && beats_seen == 4) && n < 50) begin
         @(posedge axis_clk);
         #1;
         n++;
      end
      check("beat4_wait", beats_seen, 4);
      axis_rst_n = 1'b0;
      #1;
      check("mid_rst_sm_tvalid", {31'b0, sm_tvalid}, 0);
      check("mid_rst_sm_tlast", {31'b0, sm_tlast}, 0);
      check("mid_rst_bram_re", {31'b0, bram_re}, 0);
      check("mid_rst_bram_we", {31'b0, bram_we}, 0);
      check("mid_rst_busy", {31'b0, busy}, 1);
      check("mid_rst_ss_tready", {31'b0, ss_tready}, 0);
      exp_q.delete();
      model_zero();
      repeat (2) @(posedge axis_clk);
      #1;
      axis_rst_n = 1'b1;
      check_init();
      send(32'h33, 1'b1);
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fir_tap_buffer_ctrl.md
# fir_tap_buffer_ctrl

Controller that drives an 11-entry simple dual-port block RAM as a circular sample history for the FIR datapath. It accepts one input sample per AXI-Stream beat and writes it into the RAM. It then reads back the last TAPS samples, newest to oldest, as a burst on an output stream for the MAC stage. It absorbs the RAM's one-cycle registered read latency and the downstream backpressure without losing or duplicating beats.

## Interface
- ADDR_WIDTH, 12: RAM address width.
- BIT_WIDTH, 32: sample width.
- TAPS, 11: history depth and burst length; RAM entries 0..TAPS-1 are used.
---
- axis_clk  in  1  single clock; all logic on rising edge.
- axis_rst_n  in  1  reset, asynchronous assert, active-low.
- clear  in  1  synchronous request to zero the history; sampled only in IDLE.
- ss_tvalid  in  1  input sample valid.
- ss_tready  out  1  input sample accepted when high with ss_tvalid.
- ss_tdata  in  BIT_WIDTH  input sample.
- ss_tlast  in  1  end-of-stream marker for this sample.
- sm_tvalid  out  1  output beat valid.
- sm_tready  in  1  downstream ready.
- sm_tdata  out  BIT_WIDTH  history sample x[n-k]; wired directly from bram_rdo.
- sm_tlast  out  1  high on beat k = TAPS-1 of each burst.
- sm_teos  out  1  registered ss_tlast of the sample that started the burst; constant over the burst.
- busy  out  1  high whenever state is not IDLE.
- bram_we, bram_re  out  1  RAM write and read enables.
- bram_waddr, bram_raddr  out  ADDR_WIDTH  RAM addresses.
- bram_wdi  out  BIT_WIDTH  RAM write data.
- bram_rdo  in  BIT_WIDTH  RAM read data: registered, valid the cycle after bram_re, held while bram_re is low.

## Operation
- States: INIT, IDLE, BURST. Reset enters INIT with head=0.
- INIT: zero-fill the RAM.
  - One write per cycle to addresses 0..TAPS-1 with bram_wdi=0.
  - After the write to address TAPS-1, go to IDLE.
- IDLE:
  - ss_tready = !clear.
  - If clear=1: go to INIT and set head=0. Clear wins over a simultaneous ss_tvalid; that sample is not accepted.
  - Otherwise, on ss_tvalid&&ss_tready: bram_we=1, bram_waddr=head, bram_wdi=ss_tdata in the same cycle. Latch ss_tlast into sm_teos, set rd_ptr=head and k=0, go to BURST. Head then advances: head==TAPS-1 ? 0 : head+1.
- BURST: issue a read when the output slot is free.
  - issue = (k<TAPS) && (!sm_tvalid || sm_tready).
  - On issue: bram_re=1, bram_raddr=rd_ptr. rd_ptr decrements, wrapping 0 -> TAPS-1. k increments.
  - sm_tvalid is set the cycle after an issue. It clears on a handshake with no new issue.
  - sm_tlast is registered alongside sm_tvalid: 1 for the read with k=TAPS-1.
  - At most one read is outstanding. bram_re=0 under backpressure, so bram_rdo holds the presented beat stable.
  - Go to IDLE on the handshake of the sm_tlast beat.
- clear outside IDLE is ignored.
- ss_tready=0 in INIT and BURST.
- bram_we and bram_re are never both 1 in the same cycle.
- Beat k of the burst for sample n is x[n-k]. Positions never written since INIT read 0.

## Timing
- Reset values: ss_tready=0, sm_tvalid=0, sm_tlast=0, sm_teos=0, bram_we=0, bram_re=0, bram_waddr=0, bram_raddr=0, bram_wdi=0, busy=1.
- INIT timing: after reset release, cycles 0..TAPS-1 write zeros. ss_tready first rises in cycle TAPS.
- Burst latency: sample accepted in cycle t. First read issued in t+1. Beat 0 valid in t+2.
- With sm_tready held high, beats occupy t+2..t+TAPS+1 and sm_tlast is in t+TAPS+1. State is IDLE again in t+TAPS+2.
- Sustained rate: one sample per TAPS+2 cycles.
- Reset mid-operation: asynchronous return to INIT. Any burst in progress is abandoned with no further beats. The history is re-zeroed.

## Test plan
- Reset release -> 11 zero writes to addresses 0..10; ss_tready rises in cycle 11; busy falls in the same cycle.
- Single sample 5 -> burst of 5,0,0,0,0,0,0,0,0,0,0; sm_tlast only on beat 10; the burst takes cycles t+2..t+12.
- Samples 1..12 in sequence -> the burst for 12 is 12,11,...,2 (head wraps after address 10); the burst for 11 is 11..1.
- sm_tready toggled 1,0,0,1 repeating on the burst for 7 -> exactly 11 handshakes in order; sm_tdata stable while stalled; no bram_re issued while stalled.
- clear and ss_tvalid both high in IDLE after samples 1..3 -> sample not accepted; 11 zero writes; next sample 9 -> burst 9,0,...,0.
- axis_rst_n asserted at beat 4 of a burst, then released -> outputs return to reset values immediately; INIT zero-fill; ss_tlast=1 on the next sample -> sm_teos=1 for all 11 beats.
